// File: rtl/rrprioassign_pkg.sv
// Shared parameters, FSM state type and small helpers for the round-robin arbiter.
package rrprioassign_pkg;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rrarb_state_t;

  function automatic logic [IDW-1:0] onehot2bin(input logic [N-1:0] oh);
    logic [IDW-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) b = b | IDW'(i);
    end
    return b;
  endfunction

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

endpackage

// File: rtl/rrprioassign.sv
// Combinational round-robin pick: first set bit of r at or above the one-hot
// pointer p, wrapping from N-1 back to 0. Zero when r is zero.
module rrprioassign
  import rrprioassign_pkg::*;
(
  input  logic [N-1:0] r,
  input  logic [N-1:0] p,
  output logic [N-1:0] res
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] cand;
  logic [2*N-1:0] low;

  always_comb begin
    dbl  = {r, r};
    // Doubling r makes the wrapped search a plain lowest-set-bit at or above p.
    mask = ~({{N{1'b0}}, p} - {{(2*N-1){1'b0}}, 1'b1});
    cand = dbl & mask;
    low  = cand & (~cand + {{(2*N-1){1'b0}}, 1'b1});
    res  = low[N-1:0] | low[2*N-1:N];
  end

endmodule

// File: rtl/rrarbiter.sv
// Sequential round-robin arbiter: registers the grant for a whole transaction,
// bounds hold time by MAX_HOLD and rotates priority past each released owner.
module rrarbiter
  import rrprioassign_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  localparam int unsigned HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  rrarb_state_t   state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   prio_q, prio_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           timeout_q, timeout_d;
  logic [N-1:0]   res;
  logic           expire;

  rrprioassign u_pick (
    .r   (req),
    .p   (prio_q),
    .res (res)
  );

  assign expire = (MAX_HOLD != 0) && (hold_q == HCW'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    prio_d    = prio_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          gnt_d   = res;
          id_d    = onehot2bin(res);
          hold_d  = HCW'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req[id_q] || expire) begin
          gnt_d     = '0;
          id_d      = '0;
          hold_d    = '0;
          prio_d    = rotl1(gnt_q);
          // Still requesting here means the release was forced by expiry.
          timeout_d = req[id_q];
          state_d   = IDLE;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      prio_q    <= {{(N-1){1'b0}}, 1'b1};
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      prio_q    <= prio_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = (state_q == BUSY);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rrarbiter.sv
// Self-checking bench for rrarbiter (N=4, MAX_HOLD=4): index-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_rrarbiter;
  import rrprioassign_pkg::*;

  localparam int MAXH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '1;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  int npass  = 0;
  int ntotal = 0;

  rrarbiter #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: owner index (-1 when idle), cycles held, pointer index.
  int m_owner = -1;
  int m_hold  = 0;
  int m_prio  = 0;
  bit m_to    = 1'b0;

  always @(posedge clk) begin : model
    int pick;
    pick = -1;
    if (rst) begin
      m_owner <= -1;
      m_hold  <= 0;
      m_prio  <= 0;
      m_to    <= 1'b0;
    end else if (m_owner < 0) begin
      m_to <= 1'b0;
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && req[(m_prio + k) % N]) pick = (m_prio + k) % N;
      end
      if (pick >= 0) begin
        m_owner <= pick;
        m_hold  <= 1;
      end
    end else if (!req[m_owner] || m_hold == MAXH) begin
      m_to    <= req[m_owner];
      m_prio  <= (m_owner + 1) % N;
      m_owner <= -1;
      m_hold  <= 0;
    end else begin
      m_hold <= m_hold + 1;
      m_to   <= 1'b0;
    end
  end

  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] prev_req = '0;
  int           run_len  = 0;
  int           wait_cnt [N] = '{default: 0};

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_gnt;
    int           nrun;
    int           w;
    exp_gnt = '0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
    if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), m_owner);
    chk("onehot", 32'($onehot0(gnt)), 32'd1);
    if (prev_gnt != '0 && gnt != '0) chk("no_preempt", 32'(gnt), 32'(prev_gnt));
    nrun = (gnt != '0) ? run_len + 1 : 0;
    chk("hold_max", 32'(nrun <= MAXH), 32'd1);
    run_len <= nrun;
    // Count grants to others while a requester was pending at arbitration.
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        wait_cnt[i] <= 0;
      end else if (prev_gnt == '0 && gnt != '0) begin
        if (gnt[i]) w = 0;
        else if (prev_req[i]) w = wait_cnt[i] + 1;
        else w = 0;
        chk("starve", 32'(w <= N - 1), 32'd1);
        wait_cnt[i] <= w;
      end
    end
    prev_gnt <= gnt;
    prev_req <= req;
  end

  logic [N-1:0] early_exp [6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};

  initial begin
    logic [N-1:0] e;
    // Reset with all requesting.
    rst = 1'b1;
    req = 4'b1111;
    @(posedge clk); #2;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Rotation under full load: 4 grant cycles, then a timeout bubble.
    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = (i % 5 == 4) ? 4'b0000 : (4'b0001 << ((i / 5) % 4));
      chk("rot_gnt", 32'(gnt), 32'(e));
      chk("rot_timeout", 32'(timeout), 32'(i % 5 == 4));
      if (i == 0) begin
        chk("first_busy", 32'(busy), 32'd1);
        chk("first_gnt_id", 32'(gnt_id), 32'd0);
      end
    end

    // Early release, then wrap-and-skip from pointer bit 3.
    @(posedge clk); #2;
    rst = 1'b1;
    req = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    req = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (i == 1) req = 4'b0100;
      if (i == 3) req = 4'b0000;
      if (i == 4) req = 4'b0011;
      @(negedge clk);
      chk("early_gnt", 32'(gnt), 32'(early_exp[i]));
      chk("early_timeout", 32'(timeout), 32'd0);
    end

    // Reset mid-transaction drops the grant without a timeout pulse.
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    #2;
    rst = 1'b0;
    req = 4'b0010;

    // Sole requester is re-granted after the timeout bubble.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("sole_gnt", 32'(gnt), 32'((i == 4) ? 4'b0000 : 4'b0010));
      chk("sole_timeout", 32'(timeout), 32'(i == 4));
    end

    // Random traffic with sticky requests; the model checks every cycle.
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk); #2;
      req = req ^ N'($urandom & $urandom);
    end

    @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
